// File: rtl/cdb_broadcaster_pkg.sv
// ---------------------------------------------------------------------------
// cdb_broadcaster_pkg
// Shared common-data-bus definitions. The reservation station, the physical
// register file and the CDB producer all use these, so the lane count, the tag
// width and the packet layout cannot drift apart between consumers.
//
// Contents:
//   `N_WAY / `CDB_BITS : CDB lanes per cycle / physical-register tag width
//                        (can be overridden on the command line)
//   N_WAY, CDB_BITS    : the same values as package constants
//   XLEN               : result value width
//   CDB_PACKET         : {tag, value}; tag 0 means "no broadcast"
// ---------------------------------------------------------------------------
`ifndef N_WAY
`define N_WAY 3
`endif
`ifndef CDB_BITS
`define CDB_BITS 6
`endif

package cdb_broadcaster_pkg;

    localparam int N_WAY    = `N_WAY;
    localparam int CDB_BITS = `CDB_BITS;
    localparam int XLEN     = 32;

    typedef struct packed {
        logic [CDB_BITS-1:0] tag;
        logic [XLEN-1:0]     value;
    } CDB_PACKET;

endpackage

// File: rtl/cdb_broadcaster_fifo.sv
// ---------------------------------------------------------------------------
// cdb_fifo
// Multi-push / multi-pop circular completion queue. Any subset of the N_PUSH
// push ports may be valid in a cycle; the valid ones are packed into
// consecutive slots starting at tail, in ascending port order. The N_POP
// entries starting at head are always visible on head_data; the caller
// decides how many of them retire through pop_cnt.
//
// Ports:
//   clock, reset : rising-edge clock, synchronous active-high reset
//   push_valid   : per-port push request (caller guarantees there is space)
//   push_data    : per-port packet
//   pop_cnt      : number of head entries retired at this edge (<= count)
//   head_data    : entries head .. head+N_POP-1 (only the first count are valid)
//   count        : current occupancy
// ---------------------------------------------------------------------------
module cdb_fifo
    import cdb_broadcaster_pkg::*;
#(
    parameter  int N_PUSH = 4,
    parameter  int N_POP  = 3,
    parameter  int DEPTH  = 8,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [N_PUSH-1:0]      push_valid,
    input  CDB_PACKET [N_PUSH-1:0] push_data,
    input  logic [CNT_W-1:0]       pop_cnt,
    output CDB_PACKET [N_POP-1:0]  head_data,
    output logic [CNT_W-1:0]       count
);

    CDB_PACKET        mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] wr_ptr [N_PUSH];
    logic [CNT_W-1:0] push_cnt;

    // Compaction network: each valid port lands at tail plus the number of
    // valid ports below it, so sparse valids still fill a contiguous run.
    always_comb begin
        push_cnt = '0;
        for (int i = 0; i < N_PUSH; i++) begin
            wr_ptr[i] = tail + PTR_W'(push_cnt);
            push_cnt  = push_cnt + CNT_W'(push_valid[i]);
        end
    end

    always_comb begin
        for (int j = 0; j < N_POP; j++) begin
            head_data[j] = mem[head + PTR_W'(j)];
        end
    end

    // Count is kept separately from the pointers so full and empty never alias.
    always_ff @(posedge clock) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(pop_cnt);
            tail  <= tail + PTR_W'(push_cnt);
            count <= count + push_cnt - pop_cnt;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < N_PUSH; i++) begin
                if (push_valid[i]) begin
                    mem[wr_ptr[i]] <= push_data[i];
                end
            end
        end
    end

    always @(posedge clock) begin
        if (!reset) begin
            assert (int'(count) <= DEPTH);
        end
    end

endmodule

// File: rtl/cdb_broadcaster.sv
// ---------------------------------------------------------------------------
// cdb_broadcaster
// Producer end of the common data bus. Completions from N_FU functional units
// are queued in arrival order (FU0 oldest within a cycle) and up to N_WAY of
// the oldest are broadcast each cycle as {tag, value} on the CDB lanes.
// Completions with tag 0 have no destination and are dropped. The FUs are
// stalled while the queue cannot absorb a full cycle of completions.
//
// Optional feature (macro CDB_BYPASS_EN): lanes left idle by the queue are
// filled in the same cycle by that cycle's accepted completions, which then
// skip the queue. Without the macro there is no input-to-output path.
//
// Ports:
//   clock, reset   : rising-edge clock, synchronous active-high reset
//   fu_done_valid  : per-FU completion valid
//   fu_done_tag    : per-FU destination physical tag
//   fu_done_value  : per-FU result value
//   fu_stall       : FUs must hold completions; inputs ignored this cycle
//   cdb_rs_reg_idx : broadcast tags, 0 on idle lanes
//   cdb_value      : broadcast values, 0 on idle lanes
//   cdb_valid      : lane valid, equal to (cdb_rs_reg_idx[i] != 0)
//   q_count        : current queue occupancy
// ---------------------------------------------------------------------------
module cdb_broadcaster
    import cdb_broadcaster_pkg::*;
#(
    parameter  int N_FU    = 4,
    parameter  int Q_DEPTH = 8,
    localparam int CNT_W   = $clog2(Q_DEPTH + 1)
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [N_FU-1:0]                    fu_done_valid,
    input  logic [N_FU-1:0][CDB_BITS-1:0]      fu_done_tag,
    input  logic [N_FU-1:0][XLEN-1:0]          fu_done_value,
    output logic                               fu_stall,
    output logic [N_WAY-1:0][CDB_BITS-1:0]     cdb_rs_reg_idx,
    output logic [N_WAY-1:0][XLEN-1:0]         cdb_value,
    output logic [N_WAY-1:0]                   cdb_valid,
    output logic [CNT_W-1:0]                   q_count
);

    logic [N_FU-1:0]        accepted;
    logic [N_FU-1:0]        push_valid;
    CDB_PACKET [N_FU-1:0]   push_data;
    CDB_PACKET [N_WAY-1:0]  head_data;
    CDB_PACKET [N_WAY-1:0]  lane;
    logic [CNT_W-1:0]       pop_cnt;

    // Stall looks only at the registered count, not at this cycle's pops,
    // so it never depends on the broadcast path.
    always_comb begin
        fu_stall = (Q_DEPTH - int'(q_count)) < N_FU;
    end

    always_comb begin
        for (int i = 0; i < N_FU; i++) begin
            accepted[i]        = !fu_stall && fu_done_valid[i] && (fu_done_tag[i] != '0);
            push_data[i].tag   = fu_done_tag[i];
            push_data[i].value = fu_done_value[i];
        end
    end

    always_comb begin
        pop_cnt = (int'(q_count) < N_WAY) ? q_count : CNT_W'(N_WAY);
    end

    // Queued entries occupy the low lanes, oldest on lane 0. With bypass
    // enabled, accepted completions take the remaining lanes in FU order and
    // are withheld from the queue.
    always_comb begin
        lane       = '0;
        push_valid = accepted;
        for (int j = 0; j < N_WAY; j++) begin
            if (CNT_W'(j) < q_count) begin
                lane[j] = head_data[j];
            end
        end
`ifdef CDB_BYPASS_EN
        begin
            int rank;
            rank = 0;
            for (int i = 0; i < N_FU; i++) begin
                if (accepted[i] && !reset) begin
                    for (int j = 0; j < N_WAY; j++) begin
                        if (int'(q_count) + rank == j) begin
                            lane[j]       = push_data[i];
                            push_valid[i] = 1'b0;
                        end
                    end
                    rank = rank + 1;
                end
            end
        end
`endif
    end

    always_comb begin
        for (int j = 0; j < N_WAY; j++) begin
            cdb_rs_reg_idx[j] = lane[j].tag;
            cdb_value[j]      = lane[j].value;
            cdb_valid[j]      = (lane[j].tag != '0);
        end
    end

    cdb_fifo #(
        .N_PUSH (N_FU),
        .N_POP  (N_WAY),
        .DEPTH  (Q_DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push_valid (push_valid),
        .push_data  (push_data),
        .pop_cnt    (pop_cnt),
        .head_data  (head_data),
        .count      (q_count)
    );

    // A physical tag may be written back only once, so two live lanes must
    // never carry the same tag.
    always @(posedge clock) begin
        if (!reset) begin
            for (int a = 0; a < N_WAY; a++) begin
                for (int b = a + 1; b < N_WAY; b++) begin
                    assert (!(cdb_valid[a] && cdb_valid[b] &&
                              cdb_rs_reg_idx[a] == cdb_rs_reg_idx[b]));
                end
            end
        end
    end

endmodule

// File: tb/tb_cdb_broadcaster.sv
// ---------------------------------------------------------------------------
// tb_cdb_broadcaster
// Bench for cdb_broadcaster (default parameters). A queue-based model of the
// completion stream predicts q_count, fu_stall and every lane each cycle;
// directed vectors with hand-computed lane contents pin the model.
// Honours CDB_BYPASS_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_cdb_broadcaster;
    import cdb_broadcaster_pkg::*;

    localparam int NF = 4;
    localparam int QD = 8;

    logic                          clock;
    logic                          reset;
    logic [NF-1:0]                 fu_done_valid;
    logic [NF-1:0][CDB_BITS-1:0]   fu_done_tag;
    logic [NF-1:0][XLEN-1:0]       fu_done_value;
    logic                          fu_stall;
    logic [N_WAY-1:0][CDB_BITS-1:0] cdb_rs_reg_idx;
    logic [N_WAY-1:0][XLEN-1:0]    cdb_value;
    logic [N_WAY-1:0]              cdb_valid;
    logic [3:0]                    q_count;

    int n_checks = 0;
    int n_fail   = 0;
    bit model_live = 0;
    logic [CDB_BITS+XLEN-1:0] mq[$];

    cdb_broadcaster #(.N_FU(NF), .Q_DEPTH(QD)) dut (
        .clock          (clock),
        .reset          (reset),
        .fu_done_valid  (fu_done_valid),
        .fu_done_tag    (fu_done_tag),
        .fu_done_value  (fu_done_value),
        .fu_stall       (fu_stall),
        .cdb_rs_reg_idx (cdb_rs_reg_idx),
        .cdb_value      (cdb_value),
        .cdb_valid      (cdb_valid),
        .q_count        (q_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [XLEN-1:0] valueOf(input int fu, input logic [CDB_BITS-1:0] tag);
        return 32'hC0DE_0000 | (32'(fu) << 8) | 32'(tag);
    endfunction

    // Completions the FUs present this cycle that will be taken, oldest first.
    function automatic void modelAccept(input bit stalled, output logic [CDB_BITS+XLEN-1:0] acc[$]);
        acc = {};
        if (!stalled) begin
            for (int i = 0; i < NF; i++) begin
                if (fu_done_valid[i] && fu_done_tag[i] != '0) begin
                    acc.push_back({fu_done_tag[i], fu_done_value[i]});
                end
            end
        end
    endfunction

    // How many of this cycle's accepted completions go straight to the lanes.
    function automatic int bypassCount(input int sz, input int n_acc);
`ifdef CDB_BYPASS_EN
        if (reset || sz >= N_WAY) return 0;
        return (N_WAY - sz < n_acc) ? (N_WAY - sz) : n_acc;
`else
        return 0;
`endif
    endfunction

    // Compare every cycle: lanes are the oldest queued entries, then bypassed ones.
    always @(negedge clock) begin
        if (model_live) begin
            logic [CDB_BITS+XLEN-1:0] acc[$];
            logic [CDB_BITS+XLEN-1:0] exp_lane;
            int sz;
            int nbyp;
            bit st;
            sz = mq.size();
            st = (QD - sz) < NF;
            modelAccept(st, acc);
            nbyp = bypassCount(sz, acc.size());
            checkOutput("q_count", 64'(q_count), 64'(sz));
            checkOutput("fu_stall", 64'(fu_stall), 64'(st));
            for (int j = 0; j < N_WAY; j++) begin
                exp_lane = '0;
                if (j < sz) exp_lane = mq[j];
                else if (j - sz < nbyp) exp_lane = acc[j - sz];
                checkOutput($sformatf("lane%0d", j), 64'({cdb_rs_reg_idx[j], cdb_value[j]}), 64'(exp_lane));
                checkOutput($sformatf("valid%0d", j), 64'(cdb_valid[j]),
                            64'(exp_lane[CDB_BITS+XLEN-1:XLEN] != '0));
            end
        end
    end

    // Advance the model at each edge: retire up to N_WAY, append accepted.
    always @(posedge clock) begin
        if (reset) begin
            mq.delete();
            model_live = 1'b1;
        end else if (model_live) begin
            logic [CDB_BITS+XLEN-1:0] acc[$];
            int sz;
            int nbyp;
            int pops;
            sz = mq.size();
            modelAccept((QD - sz) < NF, acc);
            nbyp = bypassCount(sz, acc.size());
            pops = (sz < N_WAY) ? sz : N_WAY;
            repeat (pops) void'(mq.pop_front());
            for (int k = nbyp; k < acc.size(); k++) mq.push_back(acc[k]);
        end
    end

    task automatic setInputs(input logic [3:0] v, input logic [5:0] t0, input logic [5:0] t1,
                             input logic [5:0] t2, input logic [5:0] t3);
        fu_done_valid = v;
        fu_done_tag   = {t3, t2, t1, t0};
        for (int i = 0; i < NF; i++) fu_done_value[i] = valueOf(i, fu_done_tag[i]);
    endtask

    task automatic applyStimulus(input logic [3:0] v, input logic [5:0] t0, input logic [5:0] t1,
                                 input logic [5:0] t2, input logic [5:0] t3);
        @(posedge clock);
        #1;
        setInputs(v, t0, t1, t2, t3);
    endtask

    task automatic idle();
        applyStimulus(4'b0000, 6'd0, 6'd0, 6'd0, 6'd0);
    endtask

    task automatic checkLanes(input string name, input logic [17:0] tags,
                              input logic [2:0] valid, input int cnt);
        @(negedge clock);
        checkOutput({name, "_tags"}, 64'(cdb_rs_reg_idx), 64'(tags));
        checkOutput({name, "_valid"}, 64'(cdb_valid), 64'(valid));
        checkOutput({name, "_count"}, 64'(q_count), 64'(cnt));
    endtask

    initial begin
        reset = 1'b1;
        setInputs(4'b1111, 6'd1, 6'd2, 6'd3, 6'd4);
        repeat (2) @(posedge clock);
        checkLanes("reset_hold", 18'd0, 3'b000, 0);
        checkOutput("reset_stall", 64'(fu_stall), 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        setInputs(4'b0000, 6'd0, 6'd0, 6'd0, 6'd0);

        // Three completions in one cycle
        applyStimulus(4'b0111, 6'd33, 6'd34, 6'd35, 6'd0);
`ifdef CDB_BYPASS_EN
        checkLanes("burst3_bypass", {6'd35, 6'd34, 6'd33}, 3'b111, 0);
        idle();
        checkLanes("burst3_next", 18'd0, 3'b000, 0);
`else
        idle();
        checkLanes("burst3", {6'd35, 6'd34, 6'd33}, 3'b111, 3);
`endif
        idle();
        checkLanes("burst3_drained", 18'd0, 3'b000, 0);

        // Two full cycles of completions, then a completion offered while stalled
        applyStimulus(4'b1111, 6'd36, 6'd37, 6'd38, 6'd39);
        applyStimulus(4'b1111, 6'd36, 6'd37, 6'd38, 6'd39);
`ifdef CDB_BYPASS_EN
        checkLanes("full_b", {6'd37, 6'd36, 6'd39}, 3'b111, 1);
        applyStimulus(4'b0001, 6'd50, 6'd0, 6'd0, 6'd0);
        checkLanes("full_c", {6'd50, 6'd39, 6'd38}, 3'b111, 2);
        checkOutput("full_c_stall", 64'(fu_stall), 64'd0);
        idle();
        checkLanes("full_d", 18'd0, 3'b000, 0);
`else
        checkLanes("full_b", {6'd38, 6'd37, 6'd36}, 3'b111, 4);
        applyStimulus(4'b0001, 6'd50, 6'd0, 6'd0, 6'd0);
        checkLanes("full_c", {6'd37, 6'd36, 6'd39}, 3'b111, 5);
        checkOutput("full_c_stall", 64'(fu_stall), 64'd1);
        idle();
        checkLanes("full_d", {6'd0, 6'd39, 6'd38}, 3'b011, 2);
`endif
        repeat (2) idle();

        // Tag-0 completion is dropped
        applyStimulus(4'b1010, 6'd0, 6'd0, 6'd0, 6'd40);
`ifdef CDB_BYPASS_EN
        checkLanes("tag0_drop", {6'd0, 6'd0, 6'd40}, 3'b001, 0);
`else
        idle();
        checkLanes("tag0_drop", {6'd0, 6'd0, 6'd40}, 3'b001, 1);
`endif
        repeat (2) idle();

        // Fill, then reset mid-drain
        applyStimulus(4'b1111, 6'd51, 6'd52, 6'd53, 6'd54);
        applyStimulus(4'b1111, 6'd55, 6'd56, 6'd57, 6'd58);
        idle();
`ifdef CDB_BYPASS_EN
        checkOutput("fill_count", 64'(q_count), 64'd2);
`else
        checkOutput("fill_count", 64'(q_count), 64'd5);
`endif
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        checkLanes("after_reset", 18'd0, 3'b000, 0);
        repeat (4) idle();

        // Single completion on an empty queue
        applyStimulus(4'b0100, 6'd0, 6'd0, 6'd41, 6'd0);
`ifdef CDB_BYPASS_EN
        checkLanes("single41", {6'd0, 6'd0, 6'd41}, 3'b001, 0);
        idle();
`else
        checkLanes("single41_early", 18'd0, 3'b000, 0);
        idle();
        checkLanes("single41", {6'd0, 6'd0, 6'd41}, 3'b001, 1);
`endif
        repeat (2) idle();

        // Sparse and mixed patterns, checked by the model only
        applyStimulus(4'b0101, 6'd10, 6'd0, 6'd12, 6'd0);
        applyStimulus(4'b1010, 6'd0, 6'd13, 6'd0, 6'd15);
        applyStimulus(4'b1111, 6'd16, 6'd17, 6'd0, 6'd19);
        applyStimulus(4'b0001, 6'd20, 6'd0, 6'd0, 6'd0);
        applyStimulus(4'b1000, 6'd0, 6'd0, 6'd0, 6'd21);
        applyStimulus(4'b1111, 6'd22, 6'd23, 6'd24, 6'd25);
        repeat (5) idle();
        @(negedge clock);
        checkOutput("final_empty", 64'(q_count), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
